// File: rtl/uart_rx_ctrl_if.sv
// SIPO-control and byte-delivery bundle between the UART receive
// sequencer (master) and the shift register / pattern matcher (slave).
interface uart_rx_ctrl_if;
    logic [7:0] sipo_data;   // parallel_out of the controlled SIPO
    logic       sipo_clr;    // one-cycle clear at frame start
    logic       shift_en;    // one-cycle shift strobe
    logic       shift_bit;   // serial_in for the SIPO, valid with shift_en
    logic [7:0] data_out;    // last good byte, LSB-first UART order
    logic       data_valid;  // one-cycle pulse when data_out updates
    logic       frame_err;   // one-cycle pulse on a bad stop bit
    logic       busy;        // high whenever the sequencer is not idle

    modport master (
        input  sipo_data,
        output sipo_clr, shift_en, shift_bit,
        output data_out, data_valid, frame_err, busy
    );

    modport slave (
        output sipo_data,
        input  sipo_clr, shift_en, shift_bit,
        input  data_out, data_valid, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronizes rx, validates the start bit at
// mid-bit, strobes each mid-bit data sample into an external SIPO, checks
// the stop bit and publishes the assembled byte with a one-cycle valid.
// Runs entirely on the system clock using a bit-period counter.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 434,  // system clocks per UART bit, >= 4
    parameter bit SIPO_MSB_IN  = 1'b1  // 1: SIPO shifts into bit 7; 0: into bit 0
) (
    input  logic           clk,
    input  logic           reset,     // asynchronous, active-low
    input  logic           rx,
    uart_rx_ctrl_if.master bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          rx_meta;
    logic          rx_s;

    logic          sipo_clr_r;
    logic          shift_en_r;
    logic          shift_bit_r;
    logic [7:0]    data_out_r;
    logic          data_valid_r;
    logic          frame_err_r;
    logic          busy_r;

    logic [7:0]    sipo_rev;
    logic [7:0]    sipo_mapped;

    // A SIPO that shifts into bit 0 ends up holding the first (LSB) bit in
    // bit 7, so its contents are mirrored to recover UART LSB-first order.
    assign sipo_rev = {<<{bus.sipo_data}};

    // Select the byte ordering matching how the external SIPO shifts.
    always_comb begin
        sipo_mapped = bus.sipo_data;
        if (!SIPO_MSB_IN) begin
            sipo_mapped = sipo_rev;
        end
    end

    // Two-flop synchronizer for the asynchronous rx line; idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame sequencer with registered strobes, byte output and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            sipo_clr_r   <= 1'b0;
            shift_en_r   <= 1'b0;
            shift_bit_r  <= 1'b0;
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            sipo_clr_r   <= 1'b0;
            shift_en_r   <= 1'b0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state  <= START;
                        busy_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state      <= DATA;
                            bit_idx    <= '0;
                            sipo_clr_r <= 1'b1;
                        end else begin
                            // Line went high before mid start bit: a glitch.
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt         <= '0;
                        shift_en_r  <= 1'b1;
                        shift_bit_r <= rx_s;
                        bit_idx     <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_valid_r <= 1'b1;
                            data_out_r   <= sipo_mapped;
                            state        <= IDLE;
                            busy_r       <= 1'b0;
                        end else begin
                            frame_err_r <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    // Hold off new starts until the line break ends.
                    cnt <= '0;
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sipo_clr   = sipo_clr_r;
    assign bus.shift_en   = shift_en_r;
    assign bus.shift_bit  = shift_bit_r;
    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: two instances share one rx line, one driving an
// MSB-in SIPO model and one an LSB-in SIPO model; observed strobes and
// bytes are logged and compared against the byte each frame carried.
module tb_uart_rx_ctrl;

    localparam int CPB = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rx    = 1'b1;

    logic [7:0] sipo0 = '0;
    logic [7:0] sipo1 = '0;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl_if bus0 ();
    uart_rx_ctrl_if bus1 ();

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .SIPO_MSB_IN(1'b1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus0)
    );

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .SIPO_MSB_IN(1'b0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    assign bus0.sipo_data = sipo0;
    assign bus1.sipo_data = sipo1;

    // External shift registers: one fills from the top, one from the bottom.
    always @(posedge clk) begin
        if (bus0.sipo_clr)      sipo0 <= '0;
        else if (bus0.shift_en) sipo0 <= {bus0.shift_bit, sipo0[7:1]};
        if (bus1.sipo_clr)      sipo1 <= '0;
        else if (bus1.shift_en) sipo1 <= {sipo1[6:0], bus1.shift_bit};
    end

    // Event log, sampled on the falling edge.
    int unsigned cyc = 0;
    int unsigned clr_t[$];
    int unsigned sh_t[$];
    bit          sh_b[$];
    logic [7:0]  dv0_q[$];
    logic [7:0]  dv1_q[$];
    int unsigned fe0_n = 0, fe1_n = 0, sh1_n = 0, clr1_n = 0, overlap_n = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus0.sipo_clr) clr_t.push_back(cyc);
        if (bus0.shift_en) begin
            sh_t.push_back(cyc);
            sh_b.push_back(bus0.shift_bit);
        end
        if (bus0.data_valid) dv0_q.push_back(bus0.data_out);
        if (bus1.data_valid) dv1_q.push_back(bus1.data_out);
        if (bus0.frame_err) fe0_n++;
        if (bus1.frame_err) fe1_n++;
        if (bus1.shift_en) sh1_n++;
        if (bus1.sipo_clr) clr1_n++;
        if (bus0.sipo_clr && bus0.shift_en) overlap_n++;
        if (bus1.sipo_clr && bus1.shift_en) overlap_n++;
        if (bus0.data_valid && bus0.frame_err) overlap_n++;
        if (bus1.data_valid && bus1.frame_err) overlap_n++;
    end

    task automatic clear_log();
        clr_t.delete();
        sh_t.delete();
        sh_b.delete();
        dv0_q.delete();
        dv1_q.delete();
        fe0_n = 0; fe1_n = 0; sh1_n = 0; clr1_n = 0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 8N1 frame, LSB first; the stop level and length are selectable.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop_val;
        repeat (stop_len) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus0.sipo_clr !== 1'b0) begin errors++; $display("FAIL reset_sipo_clr: got %0b expected 0", bus0.sipo_clr); end
        checks++; if (bus0.shift_en !== 1'b0) begin errors++; $display("FAIL reset_shift_en: got %0b expected 0", bus0.shift_en); end
        checks++; if (bus0.shift_bit !== 1'b0) begin errors++; $display("FAIL reset_shift_bit: got %0b expected 0", bus0.shift_bit); end
        checks++; if (bus0.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %0h expected 00", bus0.data_out); end
        checks++; if (bus0.data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %0b expected 0", bus0.data_valid); end
        checks++; if (bus0.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b expected 0", bus0.frame_err); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus0.busy); end
        checks++; if (bus1.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out1: got %0h expected 00", bus1.data_out); end
        reset = 1'b1;
        clear_log();
        idle(10);
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", bus0.busy); end
        checks++; if (clr_t.size() !== 0) begin errors++; $display("FAIL idle_no_clr: got %0d expected 0", clr_t.size()); end
    endtask

    // One good frame: strobe count, spacing, sampled bits and delivered byte.
    task automatic test_single_frame(input logic [7:0] b);
        logic [7:0] got_bits;
        logic [7:0] got0;
        logic [7:0] got1;
        int         bad_gap;
        int         first_gap;
        clear_log();
        send_frame(b, 1'b1, CPB);
        idle(6);
        got_bits = '0;
        foreach (sh_b[i]) if (i < 8) got_bits[i] = sh_b[i];
        bad_gap = 0;
        for (int i = 1; i < sh_t.size(); i++) if (sh_t[i] - sh_t[i-1] != CPB) bad_gap++;
        first_gap = (clr_t.size() > 0 && sh_t.size() > 0) ? int'(sh_t[0] - clr_t[0]) : -1;
        got0 = (dv0_q.size() > 0) ? dv0_q[0] : 8'hxx;
        got1 = (dv1_q.size() > 0) ? dv1_q[0] : 8'hxx;
        checks++; if (clr_t.size() !== 1) begin errors++; $display("FAIL frame_clr_count: got %0d expected 1 (byte %0h)", clr_t.size(), b); end
        checks++; if (sh_t.size() !== 8) begin errors++; $display("FAIL frame_shift_count: got %0d expected 8 (byte %0h)", sh_t.size(), b); end
        checks++; if (got_bits !== b) begin errors++; $display("FAIL frame_shift_bits: got %0h expected %0h", got_bits, b); end
        checks++; if (bad_gap !== 0) begin errors++; $display("FAIL frame_shift_spacing: got %0d bad gaps expected 0", bad_gap); end
        checks++; if (first_gap !== CPB) begin errors++; $display("FAIL frame_first_shift: got %0d expected %0d", first_gap, CPB); end
        checks++; if (dv0_q.size() !== 1) begin errors++; $display("FAIL frame_dv_count: got %0d expected 1", dv0_q.size()); end
        checks++; if (got0 !== b) begin errors++; $display("FAIL frame_data_out: got %0h expected %0h", got0, b); end
        checks++; if (got1 !== b) begin errors++; $display("FAIL frame_data_out_lsbin: got %0h expected %0h", got1, b); end
        checks++; if (fe0_n !== 0) begin errors++; $display("FAIL frame_no_ferr: got %0d expected 0", fe0_n); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after: got %0b expected 0", bus0.busy); end
        checks++; if (overlap_n !== 0) begin errors++; $display("FAIL frame_strobe_overlap: got %0d expected 0", overlap_n); end
    endtask

    task automatic test_basic();
        test_single_frame(8'hA5);
        for (int k = 0; k < 4; k++) test_single_frame(8'($urandom));
    endtask

    task automatic test_glitch();
        int len;
        for (int k = 0; k < 3; k++) begin
            len = (k == 0) ? 4 : int'($urandom_range(1, 6));
            clear_log();
            rx = 1'b0;
            repeat (len) @(posedge clk);
            #1;
            idle(30);
            checks++; if (clr_t.size() !== 0) begin errors++; $display("FAIL glitch_clr: got %0d expected 0 (len %0d)", clr_t.size(), len); end
            checks++; if (sh_t.size() !== 0) begin errors++; $display("FAIL glitch_shift: got %0d expected 0 (len %0d)", sh_t.size(), len); end
            checks++; if (dv0_q.size() !== 0) begin errors++; $display("FAIL glitch_dv: got %0d expected 0 (len %0d)", dv0_q.size(), len); end
            checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %0b expected 0", bus0.busy); end
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] prev;
        prev = 8'($urandom);
        send_frame(prev, 1'b1, CPB);
        idle(10);
        clear_log();
        send_frame(8'h3C, 1'b0, 40);
        checks++; if (fe0_n !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", fe0_n); end
        checks++; if (fe1_n !== 1) begin errors++; $display("FAIL ferr_count_lsbin: got %0d expected 1", fe1_n); end
        checks++; if (dv0_q.size() !== 0) begin errors++; $display("FAIL ferr_no_dv: got %0d expected 0", dv0_q.size()); end
        checks++; if (bus0.data_out !== prev) begin errors++; $display("FAIL ferr_data_held: got %0h expected %0h", bus0.data_out, prev); end
        checks++; if (bus1.data_out !== prev) begin errors++; $display("FAIL ferr_data_held_lsbin: got %0h expected %0h", bus1.data_out, prev); end
        checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_in_break: got %0b expected 1", bus0.busy); end
        checks++; if (sh_t.size() !== 8) begin errors++; $display("FAIL ferr_shift_count: got %0d expected 8", sh_t.size()); end
        idle(6);
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %0b expected 0", bus0.busy); end
        checks++; if (clr_t.size() !== 1) begin errors++; $display("FAIL ferr_no_false_start: got %0d expected 1", clr_t.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        int         bad;
        clear_log();
        send_frame(8'h00, 1'b1, CPB);
        send_frame(8'hFF, 1'b1, CPB);
        idle(10);
        checks++; if (dv0_q.size() !== 2) begin errors++; $display("FAIL b2b_dv_count: got %0d expected 2", dv0_q.size()); end
        checks++; if (dv0_q.size() > 0 && dv0_q[0] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %0h expected 00", dv0_q[0]); end
        checks++; if (dv0_q.size() > 1 && dv0_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %0h expected ff", dv0_q[1]); end
        checks++; if (sh_t.size() !== 16) begin errors++; $display("FAIL b2b_shift_count: got %0d expected 16", sh_t.size()); end
        checks++; if (sh1_n !== 16) begin errors++; $display("FAIL b2b_shift_count_lsbin: got %0d expected 16", sh1_n); end
        checks++; if (fe0_n !== 0) begin errors++; $display("FAIL b2b_no_ferr: got %0d expected 0", fe0_n); end
        // Random run of three gapless frames.
        clear_log();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(8'($urandom));
            send_frame(exp_q[k], 1'b1, CPB);
        end
        idle(10);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (k >= dv0_q.size() || dv0_q[k] !== exp_q[k]) bad++;
            if (k >= dv1_q.size() || dv1_q[k] !== exp_q[k]) bad++;
        end
        checks++; if (dv0_q.size() !== 3) begin errors++; $display("FAIL b2b3_dv_count: got %0d expected 3", dv0_q.size()); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b3_bytes: got %0d wrong bytes expected 0", bad); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic [7:0] got0;
        b = 8'h55;
        clear_log();
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = b[3];
        repeat (CPB / 2) @(posedge clk);
        #2;
        reset = 1'b0;
        rx    = 1'b1;
        #1;
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b expected 0", bus0.busy); end
        checks++; if (bus0.data_out !== 8'h00) begin errors++; $display("FAIL midrst_data_out: got %0h expected 00", bus0.data_out); end
        checks++; if (bus0.shift_bit !== 1'b0) begin errors++; $display("FAIL midrst_shift_bit: got %0b expected 0", bus0.shift_bit); end
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_lsbin: got %0b expected 0", bus1.busy); end
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(CPB * 4);
        checks++; if (dv0_q.size() !== 0) begin errors++; $display("FAIL midrst_no_dv: got %0d expected 0", dv0_q.size()); end
        checks++; if (fe0_n !== 0) begin errors++; $display("FAIL midrst_no_ferr: got %0d expected 0", fe0_n); end
        checks++; if (sh_t.size() !== 3) begin errors++; $display("FAIL midrst_partial_shifts: got %0d expected 3", sh_t.size()); end
        clear_log();
        send_frame(8'h81, 1'b1, CPB);
        idle(6);
        got0 = (dv0_q.size() > 0) ? dv0_q[0] : 8'hxx;
        checks++; if (dv0_q.size() !== 1) begin errors++; $display("FAIL midrst_after_dv: got %0d expected 1", dv0_q.size()); end
        checks++; if (got0 !== 8'h81) begin errors++; $display("FAIL midrst_after_data: got %0h expected 81", got0); end
    endtask

    task automatic test_lsb_in();
        logic [7:0] b;
        logic [7:0] rev;
        b = 8'h12;
        for (int i = 0; i < 8; i++) rev[7 - i] = b[i];
        clear_log();
        send_frame(b, 1'b1, CPB);
        idle(6);
        checks++; if (dv1_q.size() !== 1) begin errors++; $display("FAIL lsbin_dv_count: got %0d expected 1", dv1_q.size()); end
        checks++; if (bus1.data_out !== b) begin errors++; $display("FAIL lsbin_data_out: got %0h expected %0h", bus1.data_out, b); end
        checks++; if (sipo1 !== rev) begin errors++; $display("FAIL lsbin_sipo_raw: got %0h expected %0h", sipo1, rev); end
        checks++; if (clr1_n !== 1) begin errors++; $display("FAIL lsbin_clr_count: got %0d expected 1", clr1_n); end
        checks++; if (bus0.data_out !== b) begin errors++; $display("FAIL msbin_data_out: got %0h expected %0h", bus0.data_out, b); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_lsb_in();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
